// File: rtl/user_sha_obi_sbr_pkg.sv
// Shared types and register map for the SHA-256 OBI subordinate.
package user_sha_obi_sbr_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 4;

  typedef struct packed {
    logic                    req;
    logic                    we;
    logic [3:0]              be;
    logic [ObiAddrWidth-1:0] addr;
    logic [ObiDataWidth-1:0] wdata;
    logic [ObiIdWidth-1:0]   aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic                    gnt;
    logic                    rvalid;
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
    logic [ObiIdWidth-1:0]   rid;
  } sbr_obi_rsp_t;

  // Placement of this subordinate inside the user domain window.
  localparam logic [31:0] UserShaAddrOffset = 32'h0000_1000;
  localparam logic [31:0] UserShaAddrRange  = 32'h0000_1000;

  // Register byte offsets inside the 4 KiB window.
  localparam logic [31:0] ShaMsgOffset    = 32'h0000_0000;
  localparam logic [31:0] ShaCtrlOffset   = 32'h0000_0040;
  localparam logic [31:0] ShaStatusOffset = 32'h0000_0044;
  localparam logic [31:0] ShaDigestOffset = 32'h0000_0060;

  localparam int unsigned ShaMsgWords    = 16;
  localparam int unsigned ShaDigestWords = 8;

  typedef enum logic [1:0] {
    ShaIdle,
    ShaOffer,
    ShaCompute
  } sha_fsm_e;

  // Byte-enable merge of a write into an existing 32-bit word.
  function automatic logic [31:0] sha_be_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_sha_obi_resp.sv
// One-deep OBI response register: a granted request yields rvalid one
// cycle later with registered rdata/err/rid.
module user_sha_obi_resp #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic                 err_i,
  input  logic [IdWidth-1:0]   id_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic [IdWidth-1:0]   rid_o
);

  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;
  logic [IdWidth-1:0]   rid_q;

  // Capture the response of the request granted this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= valid_i;
      rdata_q  <= valid_i ? rdata_i : '0;
      err_q    <= valid_i & err_i;
      rid_q    <= valid_i ? id_i : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign rid_o    = rid_q;

endmodule

// File: rtl/user_sha_obi_sbr.sv
// OBI subordinate fronting a SHA-256 compression core: message/digest
// register bank, control/status, and the block/digest handshake.
module user_sha_obi_sbr
  import user_sha_obi_sbr_pkg::*;
#(
  parameter type         obi_req_t  = sbr_obi_req_t,
  parameter type         obi_rsp_t  = sbr_obi_rsp_t,
  parameter logic [31:0] AddrOffset = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  obi_req_t       obi_req_i,
  output obi_rsp_t       obi_rsp_o,
  output logic           blk_valid_o,
  input  logic           blk_ready_i,
  output logic           blk_init_o,
  output logic [511:0]   blk_msg_o,
  input  logic           dig_valid_i,
  input  logic [255:0]   dig_i,
  output logic           busy_o
);

  localparam logic [9:0] CtrlIdx   = ShaCtrlOffset[11:2];
  localparam logic [9:0] StatusIdx = ShaStatusOffset[11:2];
  localparam logic [6:0] DigestBlk = ShaDigestOffset[11:5];

  sha_fsm_e    state_q;
  logic        blk_valid_q;
  logic        blk_init_q;
  logic        busy_q;
  logic        done_q;
  logic        init_q;
  logic [31:0] msg_q    [ShaMsgWords];
  logic [31:0] digest_q [ShaDigestWords];

  logic [11:0] rel_addr;
  logic [9:0]  word_idx;
  logic        is_msg, is_ctrl, is_status, is_dig, mapped;
  logic        busy, acc_err, wr_ok;
  logic        msg_we, ctrl_we, status_we, start;
  logic        init_d;
  logic [31:0] rdata_c;
  logic        rvalid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [ObiIdWidth-1:0] rsp_rid;
  logic        unused_addr_bits;

  // Only bits [11:2] of the window-relative address select a register.
  assign rel_addr = obi_req_i.addr[11:0] - AddrOffset[11:0];
  assign word_idx = rel_addr[11:2];
  assign unused_addr_bits = ^{rel_addr[1:0], obi_req_i.addr[31:12]};

  assign is_msg    = (word_idx[9:4] == 6'd0);
  assign is_ctrl   = (word_idx == CtrlIdx);
  assign is_status = (word_idx == StatusIdx);
  assign is_dig    = (word_idx[9:3] == DigestBlk);
  assign mapped    = is_msg | is_ctrl | is_status | is_dig;

  assign busy = (state_q != ShaIdle);

  assign acc_err = ~mapped
                 | (obi_req_i.we & is_dig)
                 | (obi_req_i.we & (is_msg | is_ctrl) & busy)
                 | (~obi_req_i.we & is_dig & busy);

  assign wr_ok     = obi_req_i.req & obi_req_i.we & ~acc_err;
  assign msg_we    = wr_ok & is_msg;
  assign ctrl_we   = wr_ok & is_ctrl;
  assign status_we = wr_ok & is_status;
  // ctrl_we already implies IDLE, since CTRL writes error while busy.
  assign start     = ctrl_we & obi_req_i.be[0] & obi_req_i.wdata[0];
  assign init_d    = (ctrl_we & obi_req_i.be[0]) ? obi_req_i.wdata[1] : init_q;

  // Read mux; writes and erroring accesses return zero.
  always_comb begin
    rdata_c = '0;
    if (!obi_req_i.we && !acc_err) begin
      if (is_msg)         rdata_c = msg_q[word_idx[3:0]];
      else if (is_ctrl)   rdata_c = {30'd0, init_q, 1'b0};
      else if (is_status) rdata_c = {30'd0, done_q, busy};
      else if (is_dig)    rdata_c = digest_q[word_idx[2:0]];
    end
  end

  // Message words, byte-enable aware.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ShaMsgWords; i++) msg_q[i] <= '0;
    end else if (msg_we) begin
      msg_q[word_idx[3:0]] <= sha_be_merge(msg_q[word_idx[3:0]],
                                           obi_req_i.wdata, obi_req_i.be);
    end
  end

  // INIT control bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) init_q <= 1'b0;
    else       init_q <= init_d;
  end

  // Start/done FSM with registered handshake outputs, DONE and digest.
  // The W1C of DONE is applied before the state case so a same-cycle
  // digest arrival sets DONE over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ShaIdle;
      blk_valid_q <= 1'b0;
      blk_init_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < ShaDigestWords; i++) digest_q[i] <= '0;
    end else begin
      if (status_we && obi_req_i.be[0] && obi_req_i.wdata[1]) done_q <= 1'b0;
      case (state_q)
        ShaIdle: begin
          if (start) begin
            state_q     <= ShaOffer;
            blk_valid_q <= 1'b1;
            blk_init_q  <= init_d;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        ShaOffer: begin
          if (blk_ready_i) begin
            state_q     <= ShaCompute;
            blk_valid_q <= 1'b0;
          end
        end
        ShaCompute: begin
          if (dig_valid_i) begin
            state_q <= ShaIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            for (int unsigned i = 0; i < ShaDigestWords; i++)
              digest_q[i] <= dig_i[255-32*i -: 32];
          end
        end
        default: begin
          state_q     <= ShaIdle;
          blk_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // MSG[0] occupies the most significant word of the block.
  always_comb begin
    blk_msg_o = '0;
    for (int unsigned i = 0; i < ShaMsgWords; i++)
      blk_msg_o[511-32*i -: 32] = msg_q[i];
  end

  assign blk_valid_o = blk_valid_q;
  assign blk_init_o  = blk_init_q;
  assign busy_o      = busy_q;

  user_sha_obi_resp #(
    .DataWidth (32),
    .IdWidth   (ObiIdWidth)
  ) u_resp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (obi_req_i.req),
    .rdata_i  (rdata_c),
    .err_i    (acc_err),
    .id_i     (obi_req_i.aid),
    .rvalid_o (rvalid),
    .rdata_o  (rsp_rdata),
    .err_o    (rsp_err),
    .rid_o    (rsp_rid)
  );

  // Bus response: grant is immediate, the rest comes from the register.
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid;
    obi_rsp_o.rdata  = rsp_rdata;
    obi_rsp_o.err    = rsp_err;
    obi_rsp_o.rid    = rsp_rid;
  end

endmodule

// File: tb/tb_user_sha_obi_sbr.sv
// Directed self-checking bench for user_sha_obi_sbr.
module tb_user_sha_obi_sbr;
  import user_sha_obi_sbr_pkg::*;

  logic         clk;
  logic         rst;
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;
  logic         blk_valid, blk_ready, blk_init, dig_valid, busy;
  logic [511:0] blk_msg;
  logic [255:0] dig;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] msg_m [16];
  logic [31:0] rd_data;
  logic        rd_err, rd_valid;
  logic [3:0]  rd_id;

  localparam logic [255:0] DigAbc =
    256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
  localparam logic [255:0] Dig2 =
    256'h01234567_89ABCDEF_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_DEADBEEF_CAFEF00D;

  user_sha_obi_sbr #(
    .AddrOffset (32'h0000_0000)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .obi_req_i   (req),
    .obi_rsp_o   (rsp),
    .blk_valid_o (blk_valid),
    .blk_ready_i (blk_ready),
    .blk_init_o  (blk_init),
    .blk_msg_o   (blk_msg),
    .dig_valid_i (dig_valid),
    .dig_i       (dig),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pack_msg();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[511-32*i -: 32] = msg_m[i];
    return v;
  endfunction

  // One access; called at posedge+1, returns at the following posedge+1.
  task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] aid);
    req.req = 1'b1; req.we = we; req.be = be; req.addr = addr;
    req.wdata = wdata; req.aid = aid;
    #1;
    check("gnt", rsp.gnt, 1'b1);
    @(posedge clk); #1;
    req = '0;
    rd_valid = rsp.rvalid; rd_data = rsp.rdata; rd_err = rsp.err; rd_id = rsp.rid;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] be, input logic exp_err);
    xfer(1'b1, be, addr, wdata, 4'h0);
    check({tag, "_rvalid"}, rd_valid, 1'b1);
    check({tag, "_err"}, rd_err, exp_err);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic exp_err);
    xfer(1'b0, 4'hF, addr, 32'h0, 4'h0);
    check({tag, "_rvalid"}, rd_valid, 1'b1);
    check({tag, "_data"}, rd_data, exp_data);
    check({tag, "_err"}, rd_err, exp_err);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    req = '0; blk_ready = 0; dig_valid = 0; dig = '0;
    rst = 1;
    for (int i = 0; i < 16; i++) msg_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", rsp.rvalid, 0);
    check("rst_err", rsp.err, 0);
    check("rst_rdata", rsp.rdata, 0);
    check("rst_rid", rsp.rid, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    step();

    // Message write/readback with ID echo.
    for (int i = 0; i < 16; i++) begin
      wr("msg_wr", 32'(4*i), 32'(i), 4'hF, 0);
      check("msg_wr_rdata", rd_data, 0);
      msg_m[i] = 32'(i);
    end
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 4'hF, 32'(4*i), 32'h0, 4'(i) ^ 4'h5);
      check("msg_rd_rvalid", rd_valid, 1);
      check("msg_rd_data", rd_data, 32'(i));
      check("msg_rd_err", rd_err, 0);
      check("msg_rd_rid", rd_id, 4'(i) ^ 4'h5);
    end

    // Partial write.
    wr("m3_full", 32'h0C, 32'h1111_1111, 4'hF, 0);
    wr("m3_part", 32'h0C, 32'hAABB_CCDD, 4'b0010, 0);
    msg_m[3] = 32'h1111_CC11;
    rd("m3_rd", 32'h0C, 32'h1111_CC11, 0);

    // blk_ready in IDLE is ignored.
    blk_ready = 1; step(); blk_ready = 0;
    check("idle_ready_busy", busy, 0);
    check("idle_ready_valid", blk_valid, 0);

    // Start with INIT; core holds off.
    wr("start", 32'h40, 32'h3, 4'hF, 0);
    for (int i = 0; i < 5; i++) begin
      check("offer_valid", blk_valid, 1);
      check("offer_init", blk_init, 1);
      check("offer_msg", blk_msg == pack_msg(), 1);
      step();
    end
    rd("offer_status", 32'h44, 32'h1, 0);
    rd("ctrl_rd", 32'h40, 32'h2, 0);
    // Digest pulse during OFFER is ignored.
    dig_valid = 1; dig = Dig2; step(); dig_valid = 0; dig = '0;
    check("offer_dig_valid", blk_valid, 1);
    check("offer_dig_busy", busy, 1);
    blk_ready = 1; step(); blk_ready = 0;
    check("compute_valid", blk_valid, 0);
    check("compute_busy", busy, 1);

    // Busy errors.
    wr("busy_msg_wr", 32'h00, 32'hDEAD_BEEF, 4'hF, 1);
    check("busy_msg_wr_rdata", rd_data, 0);
    rd("busy_dig_rd", 32'h60, 32'h0, 1);
    wr("busy_ctrl_wr", 32'h40, 32'h1, 4'hF, 1);
    rd("busy_msg_rd", 32'h00, 32'h0, 0);

    // Digest delivery.
    dig_valid = 1; dig = DigAbc; step(); dig_valid = 0; dig = '0;
    check("done_busy", busy, 0);
    rd("done_status", 32'h44, 32'h2, 0);
    for (int i = 0; i < 8; i++)
      rd("dig_rd", 32'(32'h60 + 4*i), DigAbc[255-32*i -: 32], 0);

    // W1C of DONE.
    wr("w1c", 32'h44, 32'h2, 4'hF, 0);
    rd("w1c_status", 32'h44, 32'h0, 0);

    // Idle errors.
    rd("unmapped_100", 32'h100, 32'h0, 1);
    rd("unmapped_048", 32'h48, 32'h0, 1);
    wr("dig_wr", 32'h68, 32'h1234_5678, 4'hF, 1);
    rd("dig2_keep", 32'h68, 32'h4141_40DE, 0);

    // Second run without INIT; W1C collides with digest arrival.
    wr("start2", 32'h40, 32'h1, 4'hF, 0);
    check("start2_init", blk_init, 0);
    check("start2_valid", blk_valid, 1);
    blk_ready = 1; step(); blk_ready = 0;
    req.req = 1; req.we = 1; req.be = 4'hF; req.addr = 32'h44;
    req.wdata = 32'h2; req.aid = 4'h0;
    dig_valid = 1; dig = Dig2;
    step();
    req = '0; dig_valid = 0; dig = '0;
    check("collide_err", rsp.err, 0);
    rd("collide_status", 32'h44, 32'h2, 0);
    rd("dig7", 32'h7C, 32'hCAFE_F00D, 0);

    // Reset during COMPUTE with a request in flight.
    wr("start3", 32'h40, 32'h1, 4'hF, 0);
    blk_ready = 1; step(); blk_ready = 0;
    check("pre_rst_busy", busy, 1);
    rst = 1;
    req.req = 1; req.we = 0; req.be = 4'hF; req.addr = 32'h00; req.aid = 4'h3;
    step();
    rst = 0; req = '0;
    check("rst_inflight_rvalid", rsp.rvalid, 0);
    check("rst_mid_valid", blk_valid, 0);
    check("rst_mid_busy", busy, 0);
    step();
    rd("rst_status", 32'h44, 32'h0, 0);
    rd("rst_msg0", 32'h00, 32'h0, 0);
    rd("rst_dig0", 32'h60, 32'h0, 0);
    for (int i = 0; i < 16; i++) msg_m[i] = '0;
    wr("start4", 32'h40, 32'h1, 4'hF, 0);
    check("start4_valid", blk_valid, 1);
    check("start4_init", blk_init, 0);
    check("start4_msg", blk_msg == pack_msg(), 1);
    rd("start4_status", 32'h44, 32'h1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/user_sha_obi_sbr.md
Name: user_sha_obi_sbr

Overview:
- OBI subordinate in the user domain that fronts a SHA-256 compression core. Occupies one demux rule in user_pkg (4 KiB window at croc_pkg::UserBaseAddr + 32'h1000).
- Software writes a 512-bit message block, starts a compression, polls status and reads the 256-bit digest.
- The block owns the bus-side register bank, the OBI response path and the start/done handshake toward the core.

Parameters:
- obi_req_t, croc_pkg::sbr_obi_req_t, OBI subordinate request struct
- obi_rsp_t, croc_pkg::sbr_obi_rsp_t, OBI subordinate response struct
- AddrOffset, 32'h0000_0000, base subtracted before decode; only bits [11:2] are decoded

Ports:
- clk_i in 1: clock
- rst_i in 1: reset, synchronous, active-high
- obi_req_i in obi_req_t: OBI request (req, we, be, addr, wdata, aid)
- obi_rsp_o out obi_rsp_t: OBI response (gnt, rvalid, rdata, err, rid)
- blk_valid_o out 1: block offered to core
- blk_ready_i in 1: core accepts block
- blk_init_o out 1: core starts from IV (else chains previous state)
- blk_msg_o out 512: MSG[0] in bits [511:480] … MSG[15] in bits [31:0]
- dig_valid_i in 1: one-cycle pulse, digest available
- dig_i in 256: digest, H0 in [255:224]
- busy_o out 1: status mirror for interrupt/debug

Behaviour:
- Register map (byte offset):
  - 0x000-0x03C MSG[0..15], RW, byte-enable honoured.
  - 0x040 CTRL: bit0 START (write-1 pulse, reads 0); bit1 INIT (RW, be[0]).
  - 0x044 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-clears).
  - 0x060-0x07C DIGEST[0..7], RO.
  - Everything else is unmapped.
- OBI timing:
  - gnt = req combinationally, no stalls.
  - rvalid exactly one cycle after each granted request; rid = registered aid.
  - rdata and err are registered with rvalid; rdata = 0 for writes and for errors.
  - Back-to-back requests give back-to-back responses.
- err = 1 for any of:
  - unmapped offset;
  - write to DIGEST;
  - write to MSG or CTRL while BUSY;
  - read of DIGEST while BUSY.
- Erroring writes have no side effects.
- FSM states IDLE, OFFER, COMPUTE:
  - IDLE → OFFER on an accepted CTRL write with wdata[0] = 1 and be[0] = 1. The same cycle clears DONE and latches INIT into blk_init_o.
  - OFFER: blk_valid_o = 1, held stable until blk_ready_i; blk_msg_o / blk_init_o constant. OFFER → COMPUTE on blk_ready_i.
  - COMPUTE → IDLE on dig_valid_i. The same cycle captures dig_i into DIGEST and sets DONE.
  - BUSY = (state != IDLE); busy_o = BUSY.
- Boundary cases:
  - dig_valid_i in IDLE or OFFER is ignored.
  - blk_ready_i outside OFFER is ignored.
  - STATUS write-1-clear of DONE in the same cycle as dig_valid_i: set wins.
  - START and INIT may be written in the same access; INIT takes the new value.
- Reset (any cycle, including mid-operation) forces:
  - state IDLE; MSG, DIGEST, INIT, DONE = 0;
  - blk_valid_o = 0, rvalid = 0, err = 0, rdata = 0, rid = 0.
  - A request in flight during reset gets no response.
- No arithmetic in this block; all registers are 32-bit; the address compare uses bits [11:2] only.

Decomposition:
- user_pkg additions:
  - UserShaAddrOffset, UserShaAddrRange = 32'h1000;
  - idx 2 rule in user_addr_map; NumUserDomainSubordinates = 2;
  - register offset localparams ShaMsgOffset, ShaCtrlOffset, ShaStatusOffset, ShaDigestOffset;
  - typedef enum sha_fsm_e {ShaIdle, ShaOffer, ShaCompute}.
- One natural sub-module: user_sha_obi_resp, the 1-deep response register (rvalid/rdata/err/rid). It is reusable by other user subordinates.

Test Plan:
- Write MSG[0..15] = 32'h0000_0000…32'h0000_000F, read back → rvalid at t+1, rdata matches, err = 0, rid echoes aid.
- Partial write be = 4'b0010, wdata 32'hAABB_CCDD to MSG[3] holding 32'h1111_1111 → reads 32'h1111_CC11.
- Write CTRL = 32'h3; hold blk_ready_i = 0 for 5 cycles → blk_valid_o high and blk_msg_o stable throughout, blk_init_o = 1, STATUS reads 32'h1; raise ready, then pulse dig_valid_i with dig_i = 256'hBA7816BF…F20015AD → STATUS = 32'h2, DIGEST[0] = 32'hBA7816BF.
- While BUSY, write MSG[0] and read DIGEST[0] → both err = 1, MSG[0] unchanged.
- Read offset 0x100 and write DIGEST[2] in IDLE → err = 1, rdata = 0.
- Assert rst_i during COMPUTE → next cycle blk_valid_o = 0, STATUS = 0, MSG[0] = 0; the following START works normally.
